// File: rtl/pe_ws_dbuf.sv
// rtl/pe_ws_dbuf.sv - weight-stationary systolic PE with double-buffered weight
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   data_valid_in     activation valid from left neighbour
//   data_in           signed activation from left neighbour
//   psum_in           signed partial sum from upper neighbour
//   w_load_en         capture {weight_ready_in, weight_in} into the shadow register
//   weight_in         signed weight from upper neighbour
//   weight_ready_in   valid tag travelling with weight_in
//   w_swap            promote shadow weight to active (only if shadow tag set)
//   ovf_clr           clears the sticky overflow flag
//   data_valid_out    registered data_valid_in
//   data_out          registered activation to right neighbour
//   weight_out        shadow weight, chained to lower neighbour
//   weight_ready_out  shadow valid tag, chained to lower neighbour
//   psum_out          registered partial sum to lower neighbour
//   psum_valid_out    psum_out valid
//   active_ready      active weight holds a valid value
//   ovf_flag          sticky accumulation overflow indicator

module pe_ws_dbuf #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24,
    parameter int SATURATE     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [ACC_WIDTH-1:0]    psum_in,
    input  logic                    w_load_en,
    input  logic [WEIGHT_WIDTH-1:0] weight_in,
    input  logic                    weight_ready_in,
    input  logic                    w_swap,
    input  logic                    ovf_clr,
    output logic                    data_valid_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [WEIGHT_WIDTH-1:0] weight_out,
    output logic                    weight_ready_out,
    output logic [ACC_WIDTH-1:0]    psum_out,
    output logic                    psum_valid_out,
    output logic                    active_ready,
    output logic                    ovf_flag
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
    // Extra sign bits needed to bring the product up to the ACC_WIDTH+1 sum width.
    localparam int EXT_WIDTH  = ACC_WIDTH + 1 - PROD_WIDTH;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [WEIGHT_WIDTH-1:0] active_w;

    logic                    swap_ok;
    logic                    compute;
    logic                    bypass;

    logic signed [PROD_WIDTH-1:0] data_ext;
    logic signed [PROD_WIDTH-1:0] weight_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic [ACC_WIDTH:0]           sum_wide;
    logic                         sum_ovf;
    logic [ACC_WIDTH-1:0]         sum_final;

    // A swap is only honoured when the shadow register actually holds a weight.
    assign swap_ok = w_swap & weight_ready_out;
    assign compute = data_valid_in & active_ready;
    assign bypass  = data_valid_in & ~active_ready;

    // Both operands are sign-extended to the full product width so the
    // multiply yields the exact signed product with no truncation.
    assign data_ext   = {{WEIGHT_WIDTH{data_in[DATA_WIDTH-1]}}, data_in};
    assign weight_ext = {{DATA_WIDTH{active_w[WEIGHT_WIDTH-1]}}, active_w};
    assign product    = data_ext * weight_ext;

    // One guard bit above ACC_WIDTH: overflow shows up as the two top bits
    // disagreeing, and the guard bit gives the true sign of the sum.
    assign sum_wide = {psum_in[ACC_WIDTH-1], psum_in}
                    + {{EXT_WIDTH{product[PROD_WIDTH-1]}}, product};
    assign sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

    always_comb begin
        sum_final = sum_wide[ACC_WIDTH-1:0];
        if ((SATURATE != 0) && sum_ovf) begin
            sum_final = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    // Shadow and active weight registers. A load in the same cycle as a swap
    // refills the shadow, so its tag is only cleared by a swap without a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_out       <= '0;
            weight_ready_out <= 1'b0;
            active_w         <= '0;
            active_ready     <= 1'b0;
        end else begin
            if (swap_ok) begin
                active_w     <= weight_out;
                active_ready <= 1'b1;
            end
            if (w_load_en) begin
                weight_out       <= weight_in;
                weight_ready_out <= weight_ready_in;
            end else if (swap_ok) begin
                weight_ready_out <= 1'b0;
            end
        end
    end

    // Activation and partial-sum pipeline stage. The product above reads the
    // current active_w, so a same-cycle swap only affects the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else begin
            data_valid_out <= data_valid_in;
            psum_valid_out <= data_valid_in;
            if (data_valid_in) begin
                data_out <= data_in;
            end
            if (compute) begin
                psum_out <= sum_final;
            end else if (bypass) begin
                psum_out <= psum_in;
            end
        end
    end

    // Sticky overflow: a new overflow takes priority over a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
        end else if (compute && sum_ovf) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end

endmodule

// File: doc/pe_ws_dbuf.md
PE_WS_DBUF -- requirements
Module: pe_ws_dbuf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning signed activation width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, meaning signed weight width.
REQ-003 SHALL have parameter ACC_WIDTH, default 24, meaning signed partial-sum width; must satisfy ACC_WIDTH >= DATA_WIDTH+WEIGHT_WIDTH.
REQ-004 SHALL have parameter SATURATE, default 1, meaning 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-006 Ports, in this order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- data_valid_in  in  1  activation valid
- data_in  in  DATA_WIDTH  activation from left neighbour
- psum_in  in  ACC_WIDTH  partial sum from upper neighbour
- w_load_en  in  1  shadow weight capture strobe
- weight_in  in  WEIGHT_WIDTH  weight from upper neighbour
- weight_ready_in  in  1  weight-valid tag travelling with weight_in
- w_swap  in  1  shadow-to-active promotion request
- ovf_clr  in  1  clears sticky overflow
- data_valid_out  out  1  registered data_valid_in
- data_out  out  DATA_WIDTH  activation to right neighbour
- weight_out  out  WEIGHT_WIDTH  shadow weight, to lower neighbour
- weight_ready_out  out  1  shadow weight-valid tag
- psum_out  out  ACC_WIDTH  partial sum to lower neighbour
- psum_valid_out  out  1  psum_out valid
- active_ready  out  1  active weight is valid
- ovf_flag  out  1  sticky overflow indicator

Function
REQ-007 SHALL hold two weight registers: shadow (weight_out, weight_ready_out) and active (internal, active_ready).
REQ-008 On w_load_en=1, shadow SHALL capture {weight_ready_in, weight_in} at the clock edge, regardless of compute activity.
REQ-009 On w_swap=1 with weight_ready_out=1, active SHALL take shadow weight and active_ready SHALL become 1; shadow tag SHALL clear unless w_load_en=1 that cycle (load wins).
REQ-010 On w_swap=1 with weight_ready_out=0, swap SHALL be ignored; active unchanged.
REQ-011 Compute cycle (data_valid_in=1, active_ready=1): next edge SHALL register data_out=data_in, data_valid_out=1, psum_out=psum_in + sext(data_in*active_w), psum_valid_out=1; latency exactly 1 cycle.
REQ-012 Swap and compute in the same cycle: compute SHALL use the pre-swap active weight; new weight effective from the next cycle.
REQ-013 Bypass cycle (data_valid_in=1, active_ready=0): data_out/data_valid_out SHALL register as in REQ-011; psum_out SHALL equal psum_in; psum_valid_out=1; ovf_flag unaffected.
REQ-014 Idle cycle (data_valid_in=0): data_valid_out and psum_valid_out SHALL go 0; data_out and psum_out SHALL hold.
REQ-015 Arithmetic SHALL be signed; product full width DATA_WIDTH+WEIGHT_WIDTH, sign-extended to ACC_WIDTH; sum evaluated at ACC_WIDTH+1 bits.
REQ-016 Sum outside ACC_WIDTH signed range: SATURATE=1 SHALL clamp to max/min; SATURATE=0 SHALL wrap; both SHALL set ovf_flag=1 on the next edge.
REQ-017 ovf_flag SHALL be sticky until ovf_clr=1; overflow and ovf_clr same cycle: set wins.

Reset
REQ-018 rst_n=0 SHALL immediately force all registers and outputs to 0: data_out, data_valid_out, weight_out, weight_ready_out, psum_out, psum_valid_out, active_ready, ovf_flag, active weight.
REQ-019 Reset mid-compute SHALL discard any in-flight result; first valid output after release requires a new load and swap.

Verification (DATA 8, WEIGHT 8, ACC 16)
REQ-020 Load weight 3 (ready_in=1), swap, data 5, psum_in 10 -> next cycle psum_out=25, psum_valid_out=1, data_out=5.
REQ-021 Active w=3, load shadow -2 while streaming data 4, psum_in 0, swap same cycle as data 4 -> that output 12; next data 4 -> -8.
REQ-022 No swap ever, data_valid_in=1, data 7, psum_in 100 -> psum_out=100, active_ready=0, ovf_flag=0.
REQ-023 SATURATE=1, w=1, data 1, psum_in 32767 -> psum_out=32767, ovf_flag=1; SATURATE=0 -> psum_out=-32768, ovf_flag=1; ovf_clr -> 0.
REQ-024 w_swap with weight_ready_out=0 -> active_ready stays 0; w_load_en with weight 9, ready_in=1 -> weight_out=9, weight_ready_out=1 next cycle.
REQ-025 Assert rst_n=0 mid-stream -> all outputs 0 without a clock edge; after release, data_valid_in=1 yields bypass behaviour (REQ-013).
